// File: rtl/run_launcher.sv
// Debounced push-button launcher: pulses startProcess to top and times the run until endProcess.
// Optional run-length abort is compiled in with the RUN_TIMEOUT_EN macro.
module run_launcher #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 32,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             startBtn,
  input  logic             endProcess,
  output logic             startProcess,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycleCount
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic            r_sync1;
  logic            r_sync2;
  logic [DW-1:0]   r_dbCnt;
  logic            r_accept;
  logic [1:0]      r_state;
  logic            r_start;
  logic            r_busy;
  logic            r_done;
  logic [CNT_W-1:0] r_count;
  logic            w_btnS;

  assign w_btnS = r_sync2;

  // Counter saturates at DB_MAX, so a held button yields a single accept until it drops.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_dbCnt  <= '0;
      r_accept <= 1'b0;
    end else begin
      r_sync1  <= startBtn;
      r_sync2  <= r_sync1;
      r_accept <= w_btnS && (r_dbCnt == DB_LAST);
      if (!w_btnS) begin
        r_dbCnt <= '0;
      end else if (r_dbCnt != DB_MAX) begin
        r_dbCnt <= r_dbCnt + DW'(1);
      end
    end
  end

`ifdef RUN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);
  logic r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
`ifdef RUN_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (r_accept) begin
            r_state <= S_LAUNCH;
            r_start <= 1'b1;
            r_done  <= 1'b0;
            r_count <= '0;
`ifdef RUN_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
          end
        end
        S_LAUNCH: begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end
        S_RUN: begin
          // Completion wins over timeout when both land on the same cycle.
          if (endProcess) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`ifdef RUN_TIMEOUT_EN
          end else if (r_count == TO_LAST) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_count   <= TO_MAX;
`endif
          end else if (r_count != '1) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign startProcess = r_start;
  assign busy         = r_busy;
  assign done         = r_done;
  assign cycleCount   = r_count;

endmodule

// File: tb/tb_run_launcher.sv
// Directed bench for run_launcher: debounce latency, run timing, re-arm, reset and timeout.
module tb_run_launcher;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        startBtn = 1'b0;
  logic        endProcess = 1'b0;
  logic        startProcess;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycleCount;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  int lat;

  run_launcher #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .startBtn(startBtn),
    .endProcess(endProcess),
    .startProcess(startProcess),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycleCount(cycleCount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (startProcess) n_pulse++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    startBtn = 1'b0;
    endProcess = 1'b0;
    cyc(2);
    rstN = 1'b1;
    cyc(1);
  endtask

  // Raise the button and return the number of edges until startProcess is seen (20 = never).
  task automatic press(output int k);
    startBtn = 1'b1;
    k = 20;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (startProcess) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"}, {31'd0, startProcess}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_tmo"},   {31'd0, timeout}, 32'd0);
    check({tag, "_cnt"},   {16'd0, cycleCount}, 32'd0);
  endtask

  initial begin
    logic [4:0] bounce;
    int first;
    bounce = 5'b10110;

    // Reset values
    #2;
    check_idle_outputs("rst");
    do_reset();

    // Bounce then steady hold: one pulse, 7 edges after the hold begins
    n_pulse = 0;
    for (int i = 4; i >= 0; i--) begin
      startBtn = bounce[i];
      cyc(1);
      check("bounce_nostart", {31'd0, startProcess}, 32'd0);
    end
    startBtn = 1'b1;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (startProcess && first == 0) first = k;
    end
    check("bounce_lat", first, 32'd7);
    check("bounce_pulses", n_pulse, 32'd1);
    check("bounce_busy", {31'd0, busy}, 32'd1);
    check("bounce_cnt", {16'd0, cycleCount}, 32'd2);

    // Normal run: endProcess on the 30th RUN cycle
    do_reset();
    press(lat);
    startBtn = 1'b0;
    check("run_lat", lat, 32'd7);
    check("launch_busy", {31'd0, busy}, 32'd0);
    cyc(1);
    check("run1_busy", {31'd0, busy}, 32'd1);
    check("run1_cnt", {16'd0, cycleCount}, 32'd0);
    cyc(29);
    check("run30_cnt", {16'd0, cycleCount}, 32'd29);
    endProcess = 1'b1;
    cyc(1);
    endProcess = 1'b0;
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_cnt", {16'd0, cycleCount}, 32'd29);
    cyc(5);
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_cnt", {16'd0, cycleCount}, 32'd29);
    press(lat);
    startBtn = 1'b0;
    check("relaunch_lat", lat, 32'd7);
    check("relaunch_done", {31'd0, done}, 32'd0);
    check("relaunch_cnt", {16'd0, cycleCount}, 32'd0);

    // Reset in the middle of a run
    do_reset();
    press(lat);
    startBtn = 1'b0;
    cyc(5);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    check_idle_outputs("midrst");
    cyc(1);
    rstN = 1'b1;
    cyc(1);
    press(lat);
    startBtn = 1'b0;
    check("postrst_lat", lat, 32'd7);

    // Held button and extra presses during RUN
    do_reset();
    n_pulse = 0;
    press(lat);
    check("held_lat", lat, 32'd7);
    cyc(10);
    startBtn = 1'b0;
    cyc(2);
    startBtn = 1'b1;
    cyc(8);
    endProcess = 1'b1;
    cyc(1);
    endProcess = 1'b0;
    check("held_done", {31'd0, done}, 32'd1);
    cyc(10);
    check("held_pulses", n_pulse, 32'd1);
    check("held_still_done", {31'd0, done}, 32'd1);
    startBtn = 1'b0;
    cyc(2);
    press(lat);
    startBtn = 1'b0;
    check("held_new_lat", lat, 32'd7);
    cyc(1);
    check("held_new_pulses", n_pulse, 32'd2);

    // endProcess already high during LAUNCH
    do_reset();
    press(lat);
    startBtn = 1'b0;
    endProcess = 1'b1;
    cyc(1);
    check("imm_busy", {31'd0, busy}, 32'd1);
    check("imm_done0", {31'd0, done}, 32'd0);
    cyc(1);
    endProcess = 1'b0;
    check("imm_done", {31'd0, done}, 32'd1);
    check("imm_cnt", {16'd0, cycleCount}, 32'd0);

    // Timeout behaviour: 100 RUN cycles with no endProcess
    do_reset();
    press(lat);
    startBtn = 1'b0;
    cyc(101);
`ifdef RUN_TIMEOUT_EN
    check("tmo_flag", {31'd0, timeout}, 32'd1);
    check("tmo_done", {31'd0, done}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_cnt", {16'd0, cycleCount}, 32'd100);
`else
    check("notmo_flag", {31'd0, timeout}, 32'd0);
    check("notmo_busy", {31'd0, busy}, 32'd1);
    check("notmo_done", {31'd0, done}, 32'd0);
    check("notmo_cnt", {16'd0, cycleCount}, 32'd100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
